// File: rtl/add_chunked.sv
// Multi-cycle adder/subtractor: WIDTH-bit result built from CHUNK-bit ripple
// slices, LSB slice first, one slice per clock, valid/ready on both sides.
module add_chunked #(
    parameter int WIDTH = 32,   // must be an integer multiple of CHUNK
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [IW-1:0]    r_idx;
    logic             r_cout;
    logic             r_ovf;

    logic [CHUNK-1:0] w_a_slice;
    logic [CHUNK-1:0] w_b_slice;
    logic [CHUNK:0]   w_slice;
    logic             w_ovf;

    assign w_a_slice = r_a[int'(r_idx) * CHUNK +: CHUNK];
    assign w_b_slice = r_b[int'(r_idx) * CHUNK +: CHUNK];
    assign w_slice   = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{CHUNK{1'b0}}, r_carry};

    // Carry into the slice MSB is recovered as a ^ b ^ sum at that bit.
    assign w_ovf = w_a_slice[CHUNK-1] ^ w_b_slice[CHUNK-1]
                 ^ w_slice[CHUNK-1] ^ w_slice[CHUNK];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{sub}};
                        r_carry <= cin ^ sub;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[int'(r_idx) * CHUNK +: CHUNK] <= w_slice[CHUNK-1:0];
                    r_carry <= w_slice[CHUNK];
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= w_slice[CHUNK];
                        r_ovf   <= w_ovf;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
